dsp_mac_sequencer: RTL and testbench

Opmode sequencer for the DSP48A1 post-adder datapath. It runs length-N multiply-accumulate (dot-product) jobs. Per accepted operand beat it drives the 8-bit opmode and an operand-valid strobe:
- first beat clears the accumulator (X=M, Z=0);
- later beats accumulate (X=M, Z=P);
- bubbles hold P.
It sits between the operand source (valid/ready) and the DSP slice. It waits out the slice pipeline latency and then signals done.

---
 rtl/dsp_mac_sequencer.sv | 149 ++++++++++++++
 tb/tb_dsp_mac_sequencer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_mac_sequencer.sv
// rtl/dsp_mac_sequencer.sv - DSP48A1 opmode sequencer for length-N multiply-accumulate jobs
module dsp_mac_sequencer #(
  parameter int LEN_W    = 8,
  parameter int PIPE_LAT = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             use_preadd,
  input  logic             preadd_sub,
  input  logic             post_sub,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [7:0]       opmode,
  output logic             op_valid,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [3:0]       LAST_T  = 4'(PIPE_LAT - 1);

  localparam logic [1:0] Z_ZERO = 2'b00;
  localparam logic [1:0] Z_P    = 2'b10;
  localparam logic [1:0] X_ZERO = 2'b00;
  localparam logic [1:0] X_M    = 2'b01;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [3:0]       timer_q, timer_d;
  logic             first_q, first_d;
  logic             use_preadd_q, use_preadd_d;
  logic             preadd_sub_q, preadd_sub_d;
  logic             post_sub_q, post_sub_d;
  logic             err_q, err_d;

  logic [1:0]       z_sel;
  logic [7:0]       hold_op;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= S_IDLE;
      len_q        <= '0;
      cnt_q        <= '0;
      timer_q      <= '0;
      first_q      <= 1'b0;
      use_preadd_q <= 1'b0;
      preadd_sub_q <= 1'b0;
      post_sub_q   <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      timer_q      <= timer_d;
      first_q      <= first_d;
      use_preadd_q <= use_preadd_d;
      preadd_sub_q <= preadd_sub_d;
      post_sub_q   <= post_sub_d;
      err_q        <= err_d;
    end
  end

  // Until the first beat lands, Z must stay 0 so the accumulator starts clean.
  assign z_sel   = first_q ? Z_ZERO : Z_P;
  assign hold_op = {1'b0, preadd_sub_q, 1'b0, use_preadd_q, Z_P, X_ZERO};
  assign err     = err_q;

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    cnt_d        = cnt_q;
    timer_d      = timer_q;
    first_d      = first_q;
    use_preadd_d = use_preadd_q;
    preadd_sub_d = preadd_sub_q;
    post_sub_d   = post_sub_q;
    err_d        = 1'b0;
    s_ready      = 1'b0;
    op_valid     = 1'b0;
    opmode       = 8'h00;
    busy         = 1'b0;
    done         = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (len != '0) begin
            len_d        = len;
            use_preadd_d = use_preadd;
            preadd_sub_d = preadd_sub;
            post_sub_d   = post_sub;
            cnt_d        = '0;
            first_d      = 1'b1;
            state_d      = S_ISSUE;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      S_ISSUE: begin
        s_ready = 1'b1;
        busy    = 1'b1;
        if (s_valid) begin
          op_valid = 1'b1;
          opmode   = {post_sub_q, preadd_sub_q, 1'b0, use_preadd_q, z_sel, X_M};
          first_d  = 1'b0;
          cnt_d    = cnt_q + LEN_ONE;
          if (cnt_q == len_q - LEN_ONE) begin
            timer_d = '0;
            state_d = S_DRAIN;
          end
        end else begin
          opmode = {1'b0, preadd_sub_q, 1'b0, use_preadd_q, z_sel, X_ZERO};
        end
      end

      S_DRAIN: begin
        busy    = 1'b1;
        opmode  = hold_op;
        timer_d = timer_q + 4'd1;
        if (timer_q == LAST_T) begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        opmode  = hold_op;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// tb/tb_dsp_mac_sequencer.sv - scoreboard bench for dsp_mac_sequencer with a P-register model
module tb_dsp_mac_sequencer;

  localparam int LEN_W    = 8;
  localparam int PIPE_LAT = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic [LEN_W-1:0] len = '0;
  logic             use_preadd = 1'b0;
  logic             preadd_sub = 1'b0;
  logic             post_sub = 1'b0;
  logic             s_valid = 1'b0;
  logic             s_ready, op_valid, busy, done, err;
  logic [7:0]       opmode;

  int a_op = 0;
  int b_op = 0;
  int checks = 0;
  int errors = 0;
  int err_seen = 0;

  typedef struct {
    logic [7:0] hold;
    longint     p;
    int         busy_len;
  } job_t;

  logic [7:0] exp_op[$];
  logic [7:0] exp_bub[$];
  job_t       exp_job[$];

  always #5 clk = ~clk;

  dsp_mac_sequencer #(.LEN_W(LEN_W), .PIPE_LAT(PIPE_LAT)) dut (
    .CLK        (clk),
    .RST        (rst),
    .start      (start),
    .len        (len),
    .use_preadd (use_preadd),
    .preadd_sub (preadd_sub),
    .post_sub   (post_sub),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .opmode     (opmode),
    .op_valid   (op_valid),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got unexpected event expected none at %0t", name, $time);
  endtask

  // Monitor: models Z +/- A*B on accepted beats and pops expectations.
  longint p_model = 0;
  int     busy_cnt = 0;
  int     since_acc = 0;

  always @(negedge clk) begin
    longint m;
    longint z;
    if (rst) begin
      p_model   = 0;
      busy_cnt  = 0;
      since_acc = 0;
    end else begin
      if (err) err_seen++;
      if (!busy) begin
        busy_cnt = 0;
        check("idle_outputs", {s_ready, op_valid, done, opmode}, 0);
      end else begin
        busy_cnt++;
        since_acc++;
        if (s_ready && s_valid) begin
          since_acc = 0;
          check("accept_strobes", {op_valid, done}, 2'b10);
          if (exp_op.size() == 0) fail("unexpected_accept");
          else check("accept_opmode", opmode, exp_op.pop_front());
          m = longint'(a_op) * longint'(b_op);
          z = (opmode[3:2] == 2'b10) ? p_model : 0;
          p_model = opmode[7] ? z - m : z + m;
        end else if (s_ready) begin
          check("bubble_strobes", {op_valid, done}, 2'b00);
          if (exp_bub.size() == 0) fail("unexpected_bubble");
          else check("bubble_opmode", opmode, exp_bub.pop_front());
        end else begin
          check("drain_op_valid", op_valid, 0);
          if (exp_job.size() == 0) fail("unexpected_drain");
          else begin
            check("hold_opmode", opmode, exp_job[0].hold);
            if (done) begin
              check("result_p", p_model, exp_job[0].p);
              check("busy_len", busy_cnt, exp_job[0].busy_len);
              check("done_latency", since_acc, PIPE_LAT + 1);
              void'(exp_job.pop_front());
            end
          end
        end
      end
    end
  end

  task automatic start_job(input int n, input logic up, input logic ps, input logic pos);
    start      = 1'b1;
    len        = n[LEN_W-1:0];
    use_preadd = up;
    preadd_sub = ps;
    post_sub   = pos;
    @(posedge clk); #1;
    start      = 1'b0;
    len        = 8'hA5;
    use_preadd = ~up;
    preadd_sub = ~ps;
    post_sub   = ~pos;
  endtask

  task automatic issue(input logic [255:0] pat, input int npat, input logic noise);
    int k = 0;
    for (int i = 0; i < npat; i++) begin
      s_valid = pat[i];
      if (pat[i]) begin
        k++;
        a_op = k;
        b_op = k + 1;
      end else begin
        a_op = 99;
        b_op = 99;
      end
      start = noise;
      len   = 8'd7;
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    start   = 1'b0;
  endtask

  task automatic wait_drain(input logic noise);
    for (int i = 0; i < PIPE_LAT + 1; i++) begin
      start = noise;
      len   = 8'd3;
      @(posedge clk); #1;
    end
    start = 1'b0;
    check("idle_after_done", busy, 0);
  endtask

  task automatic push_job(input logic [7:0] hold, input longint p, input int blen);
    job_t j;
    j.hold = hold;
    j.p = p;
    j.busy_len = blen;
    exp_job.push_back(j);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst = 1'b1;
    #2;
    check("reset_outputs", {s_ready, op_valid, busy, done, err, opmode}, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    // len=3, continuous beats, start noise during ISSUE/DRAIN/DONE
    exp_op.push_back(8'h01); exp_op.push_back(8'h09); exp_op.push_back(8'h09);
    push_job(8'h08, 20, 8);
    start_job(3, 0, 0, 0);
    issue(256'b111, 3, 1'b1);
    wait_drain(1'b1);

    // len=1 with pre-adder and post-subtract
    exp_op.push_back(8'h91);
    push_job(8'h18, -2, 6);
    start_job(1, 1, 0, 1);
    issue(256'b1, 1, 1'b0);
    wait_drain(1'b0);

    // len=4 with bubbles: valid pattern 1,0,0,1,1,0,1
    exp_op.push_back(8'h01); exp_op.push_back(8'h09); exp_op.push_back(8'h09); exp_op.push_back(8'h09);
    exp_bub.push_back(8'h08); exp_bub.push_back(8'h08); exp_bub.push_back(8'h08);
    push_job(8'h08, 40, 12);
    start_job(4, 0, 0, 0);
    issue(256'b1011001, 7, 1'b0);
    wait_drain(1'b1);

    // len=0 rejected, then len=2
    start = 1'b1;
    len   = '0;
    @(posedge clk); #1;
    start = 1'b0;
    check("err_pulse", {err, busy}, 2'b10);
    @(posedge clk); #1;
    check("err_cleared", {err, busy}, 2'b00);
    exp_op.push_back(8'h01); exp_op.push_back(8'h09);
    push_job(8'h08, 8, 7);
    start_job(2, 0, 0, 0);
    issue(256'b11, 2, 1'b0);
    wait_drain(1'b0);

    // async reset after 2 of 5 beats
    exp_op.push_back(8'h01); exp_op.push_back(8'h09);
    start_job(5, 0, 0, 0);
    issue(256'b11, 2, 1'b0);
    s_valid = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("async_reset_outputs", {s_ready, op_valid, busy, done, opmode}, 0);
    s_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("abort_accepts_consumed", exp_op.size(), 0);
    repeat (3) @(posedge clk);
    #1;

    exp_op.push_back(8'h41); exp_op.push_back(8'h49); exp_op.push_back(8'h49);
    push_job(8'h48, 20, 8);
    start_job(3, 0, 1, 0);
    issue(256'b111, 3, 1'b0);
    wait_drain(1'b0);

    // maximum length job, no counter wrap
    exp_op.push_back(8'h01);
    for (int i = 1; i < 255; i++) exp_op.push_back(8'h09);
    push_job(8'h08, 5592320, 260);
    start_job(255, 0, 0, 0);
    issue({256{1'b1}}, 255, 1'b0);
    wait_drain(1'b0);

    repeat (3) @(posedge clk);
    #1;
    check("ops_left", exp_op.size(), 0);
    check("bubbles_left", exp_bub.size(), 0);
    check("jobs_left", exp_job.size(), 0);
    check("err_pulses", err_seen, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
